// File: rtl/fpu_sp_pkg.sv
// Shared opcodes, the quiet-NaN substitute and the issue-FSM state type for
// the fpu_sp issue stage.
package fpu_sp_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Result reported when the FPU never signals Ready.
  localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/fpu_sp_sequencer_if.sv
// Request and result handshakes of fpu_sp_sequencer. The master side produces
// requests and consumes results; the slave side is the sequencer.
interface fpu_sp_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_overflow;
  logic             out_underflow;
  logic             out_timeout;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow,
           out_timeout, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow,
           out_timeout, out_tag
  );

endinterface

// File: rtl/fpu_sp_req_fifo.sv
// Request FIFO for the fpu_sp issue stage. The head entry is copied into an
// output register on pop, so the popped request stays stable until the next
// pop regardless of later pushes.
module fpu_sp_req_fifo #(
  parameter int DW    = 70,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            din,
  input  logic                     pop,
  output logic [DW-1:0]            dout,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && (cnt != '0);
  assign count   = cnt;

  // Storage array; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and the registered head; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      dout   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fpu_sp_sequencer.sv
// Issue stage for fpu_sp: queues requests, presents one at a time on held
// operands, waits for Ready (or times out), and hands the captured result
// downstream on a valid/ready handshake.
module fpu_sp_sequencer
  import fpu_sp_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  fpu_sp_sequencer_if.slave        bus,
  output logic [WIDTH-1:0]         fpu_a,
  output logic [WIDTH-1:0]         fpu_b,
  output logic [1:0]               fpu_op,
  input  logic [WIDTH-1:0]         fpu_result,
  input  logic                     fpu_ready,
  input  logic                     fpu_overflow,
  input  logic                     fpu_underflow,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int DW = 2*WIDTH + 2 + TAG_W;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  seq_state_t       state;
  logic [TW-1:0]    timer;
  logic [DW-1:0]    head;
  logic [TAG_W-1:0] head_tag;
  logic             fifo_full;
  logic [$clog2(DEPTH):0] fifo_cnt;
  logic             pop;
  logic             handshake;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_result_q;
  logic             out_overflow_q;
  logic             out_underflow_q;
  logic             out_timeout_q;
  logic [TAG_W-1:0] out_tag_q;

  // The FIFO output register doubles as the operand register, so fpu_*
  // only move when an entry is popped, i.e. on entry to ISSUE.
  fpu_sp_req_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid),
    .din   ({bus.in_a, bus.in_b, bus.in_op, bus.in_tag}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .count (fifo_cnt)
  );

  assign {fpu_a, fpu_b, fpu_op, head_tag} = head;

  assign handshake = (state == DONE) && bus.out_ready;
  assign pop       = ((state == IDLE) || handshake) && (fifo_cnt != '0);

  assign bus.in_ready      = !fifo_full;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_result    = out_result_q;
  assign bus.out_overflow  = out_overflow_q;
  assign bus.out_underflow = out_underflow_q;
  assign bus.out_timeout   = out_timeout_q;
  assign bus.out_tag       = out_tag_q;
  assign busy              = (state != IDLE);
  assign count             = fifo_cnt;

  // Issue FSM with WAIT timer and result capture; Ready beats the timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      timer           <= '0;
      out_valid_q     <= 1'b0;
      out_result_q    <= '0;
      out_overflow_q  <= 1'b0;
      out_underflow_q <= 1'b0;
      out_timeout_q   <= 1'b0;
      out_tag_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_cnt != '0) state <= ISSUE;
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          if (fpu_ready) begin
            out_result_q    <= fpu_result;
            out_overflow_q  <= fpu_overflow;
            out_underflow_q <= fpu_underflow;
            out_timeout_q   <= 1'b0;
            out_tag_q       <= head_tag;
            out_valid_q     <= 1'b1;
            state           <= DONE;
          end else if (timer == TMAX) begin
            out_result_q    <= WIDTH'(QNAN_SP);
            out_overflow_q  <= 1'b0;
            out_underflow_q <= 1'b0;
            out_timeout_q   <= 1'b1;
            out_tag_q       <= head_tag;
            out_valid_q     <= 1'b1;
            state           <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= (fifo_cnt != '0) ? ISSUE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
